// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris command-input path.
// Holds the command encoding consumed by the active-piece update logic.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5
  } command_t;

  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_ROTATE    = 2;
  localparam int BTN_DOWN      = 3;
  localparam int BTN_HARD_DROP = 4;

  localparam int DEF_DEBOUNCE_TICKS = 8;
  localparam int DEF_DAS_TICKS      = 12;
  localparam int DEF_ARR_TICKS      = 3;

  // Tick counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tetris_btn_debounce.sv
// One button channel: 2-flop synchronizer, tick-based debounce, press edge
// and optional DAS/ARR auto-repeat, producing a one-cycle o_event pulse.
module tetris_btn_debounce
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int DAS_TICKS      = DEF_DAS_TICKS,
  parameter int ARR_TICKS      = DEF_ARR_TICKS,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic i_btn,
  output logic o_event
);

  logic [1:0] r_sync;
  logic       r_stable;
  logic       r_stable_d;
  logic [7:0] r_db_cnt;
  logic       w_synced;
  logic [7:0] w_db_inc;
  logic       w_press;

  assign w_synced = r_sync[1];
  assign w_db_inc = sat_inc(r_db_cnt);
  assign w_press  = r_stable & ~r_stable_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync     <= 2'b00;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_db_cnt   <= 8'd0;
    end else begin
      r_sync     <= {r_sync[0], i_btn};
      r_stable_d <= r_stable;
      if (tick) begin
        if (w_synced != r_stable) begin
          if (w_db_inc == 8'(DEBOUNCE_TICKS)) begin
            r_stable <= w_synced;
            r_db_cnt <= 8'd0;
          end else begin
            r_db_cnt <= w_db_inc;
          end
        end else begin
          r_db_cnt <= 8'd0;
        end
      end
    end
  end

  if (REPEAT_EN) begin : g_rep
    logic [7:0] r_rep_cnt;
    logic       r_rep_arr;
    logic       r_rep_evt;
    logic [7:0] w_rep_inc;
    logic [7:0] w_rep_target;

    assign w_rep_inc    = sat_inc(r_rep_cnt);
    assign w_rep_target = r_rep_arr ? 8'(ARR_TICKS) : 8'(DAS_TICKS);

    // First period after the press uses DAS, later ones ARR; release restarts.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_rep_cnt <= 8'd0;
        r_rep_arr <= 1'b0;
        r_rep_evt <= 1'b0;
      end else begin
        r_rep_evt <= 1'b0;
        if (!r_stable) begin
          r_rep_cnt <= 8'd0;
          r_rep_arr <= 1'b0;
        end else if (tick) begin
          if (w_rep_inc == w_rep_target) begin
            r_rep_evt <= 1'b1;
            r_rep_cnt <= 8'd0;
            r_rep_arr <= 1'b1;
          end else begin
            r_rep_cnt <= w_rep_inc;
          end
        end
      end
    end

    assign o_event = w_press | r_rep_evt;
  end else begin : g_norep
    assign o_event = w_press;
  end

endmodule

// File: rtl/tetris_cmd_input.sv
// Button-to-command front end: per-button debounce channels, pending bits,
// fixed-priority arbiter and valid/ready output register.
// Optional hard-drop channel enabled by defining TETRIS_HARD_DROP_EN.
module tetris_cmd_input
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int DAS_TICKS      = DEF_DAS_TICKS,
  parameter int ARR_TICKS      = DEF_ARR_TICKS
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     tick,
  input  logic     btn_left,
  input  logic     btn_right,
  input  logic     btn_rotate,
  input  logic     btn_down,
`ifdef TETRIS_HARD_DROP_EN
  input  logic     btn_hard_drop,
`endif
  output command_t cmd,
  output logic     cmd_valid,
  input  logic     cmd_ready
);

`ifdef TETRIS_HARD_DROP_EN
  localparam int NUM_BTN = 5;
`else
  localparam int NUM_BTN = 4;
`endif

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_evt;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] w_clr_eff;
  logic [NUM_BTN-1:0] r_pend;
  command_t           w_sel_cmd;
  command_t           r_cmd;
  logic               r_valid;
  logic               w_load;
  logic               w_handshake;

  assign w_btn[BTN_LEFT]   = btn_left;
  assign w_btn[BTN_RIGHT]  = btn_right;
  assign w_btn[BTN_ROTATE] = btn_rotate;
  assign w_btn[BTN_DOWN]   = btn_down;
`ifdef TETRIS_HARD_DROP_EN
  assign w_btn[BTN_HARD_DROP] = btn_hard_drop;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    tetris_btn_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .DAS_TICKS     (DAS_TICKS),
      .ARR_TICKS     (ARR_TICKS),
      .REPEAT_EN     ((i == BTN_LEFT) || (i == BTN_RIGHT) || (i == BTN_DOWN))
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .i_btn  (w_btn[i]),
      .o_event(w_evt[i])
    );
  end

  // NOTE: every output gets a default first so this always_comb cannot infer a latch.
  always_comb begin
    w_sel_cmd = CMD_NONE;
    w_clr     = '0;
`ifdef TETRIS_HARD_DROP_EN
    if (r_pend[BTN_HARD_DROP]) begin
      w_sel_cmd            = CMD_HARD_DROP;
      w_clr[BTN_HARD_DROP] = 1'b1;
    end else
`endif
    if (r_pend[BTN_ROTATE]) begin
      w_sel_cmd         = CMD_ROTATE;
      w_clr[BTN_ROTATE] = 1'b1;
    end else if (r_pend[BTN_LEFT]) begin
      w_sel_cmd       = CMD_LEFT;
      w_clr[BTN_LEFT] = 1'b1;
    end else if (r_pend[BTN_RIGHT]) begin
      w_sel_cmd        = CMD_RIGHT;
      w_clr[BTN_RIGHT] = 1'b1;
    end else if (r_pend[BTN_DOWN]) begin
      w_sel_cmd       = CMD_SOFT_DROP;
      w_clr[BTN_DOWN] = 1'b1;
    end
  end

  assign w_handshake = r_valid & cmd_ready;
  assign w_load      = (!r_valid || cmd_ready) && (|r_pend);
  assign w_clr_eff   = w_load ? w_clr : '0;

  // An event on an already-pending button is absorbed by the OR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_cmd   <= CMD_NONE;
    end else begin
      r_pend <= (r_pend | w_evt) & ~w_clr_eff;
      if (w_load) begin
        r_valid <= 1'b1;
        r_cmd   <= w_sel_cmd;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
        r_cmd   <= CMD_NONE;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_valid;

endmodule

// File: tb/tb_tetris_cmd_input.sv
// Directed bench for tetris_cmd_input with DEBOUNCE=4, DAS=6, ARR=2, tick every cycle.
module tb_tetris_cmd_input;
  import tetris_pkg::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     tick;
  logic     btn_left, btn_right, btn_rotate, btn_down;
`ifdef TETRIS_HARD_DROP_EN
  logic     btn_hard_drop;
`endif
  command_t cmd;
  logic     cmd_valid;
  logic     cmd_ready;

  int       n_checks = 0;
  int       n_err    = 0;
  int       hs_idx[$];
  command_t hs_cmd[$];

  always #5 clk = ~clk;

  tetris_cmd_input #(
    .DEBOUNCE_TICKS(4),
    .DAS_TICKS     (6),
    .ARR_TICKS     (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_rotate(btn_rotate),
    .btn_down  (btn_down),
`ifdef TETRIS_HARD_DROP_EN
    .btn_hard_drop(btn_hard_drop),
`endif
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic release_all();
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_rotate = 1'b0;
    btn_down   = 1'b0;
`ifdef TETRIS_HARD_DROP_EN
    btn_hard_drop = 1'b0;
`endif
  endtask

  // Runs n cycles; cycle c is the c-th posedge of the window. Buttons are
  // released just before posedge rel_at. Records cycles showing a handshake.
  task automatic watch(input int n, input int rel_at);
    hs_idx.delete();
    hs_cmd.delete();
    for (int c = 0; c < n; c++) begin
      if (c == rel_at) release_all();
      @(posedge clk);
      #1;
      if (cmd_valid && cmd_ready) begin
        hs_idx.push_back(c);
        hs_cmd.push_back(cmd);
      end
    end
  endtask

  function automatic int idx_at(input int i);
    return (i < hs_idx.size()) ? hs_idx[i] : -1;
  endfunction

  function automatic int count_not(input command_t e);
    int n = 0;
    foreach (hs_cmd[i]) if (hs_cmd[i] != e) n++;
    return n;
  endfunction

  initial begin
    reset_n   = 1'b0;
    tick      = 1'b1;
    cmd_ready = 1'b1;
    release_all();

    // 1: left held through reset; first command 2+4+2 cycles after release
    btn_left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_valid", cmd_valid, 0);
      check("rst_cmd", cmd, CMD_NONE);
    end
    reset_n = 1'b1;
    watch(20, 5);
    check("t1_first_cycle", idx_at(0), 7);
    check("t1_count", hs_idx.size(), 1);
    check("t1_wrong_cmds", count_not(CMD_LEFT), 0);

    // 2: three-tick glitch on rotate is rejected
    btn_rotate = 1'b1;
    watch(30, 3);
    check("t2_glitch_count", hs_idx.size(), 0);

    // 3: long rotate hold gives exactly one command
    btn_rotate = 1'b1;
    watch(60, 40);
    check("t3_count", hs_idx.size(), 1);
    check("t3_first_cycle", idx_at(0), 7);
    check("t3_wrong_cmds", count_not(CMD_ROTATE), 0);

    // 4: left auto-repeat: press, then +6, +8, ... +18 (stable held 20 ticks)
    btn_left = 1'b1;
    watch(45, 19);
    check("t4_count", hs_idx.size(), 8);
    check("t4_press", idx_at(0), 7);
    check("t4_das", idx_at(1), 13);
    check("t4_arr", idx_at(2), 15);
    check("t4_last", idx_at(7), 25);
    check("t4_wrong_cmds", count_not(CMD_LEFT), 0);

    // 5: simultaneous left+right under a stall
    cmd_ready = 1'b0;
    btn_left  = 1'b1;
    btn_right = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) release_all();
      @(posedge clk);
      #1;
    end
    check("t5_valid", cmd_valid, 1);
    check("t5_cmd", cmd, CMD_LEFT);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold_valid", cmd_valid, 1);
      check("t5_hold_cmd", cmd, CMD_LEFT);
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_next_valid", cmd_valid, 1);
    check("t5_next_cmd", cmd, CMD_RIGHT);
    @(posedge clk);
    #1;
    check("t5_idle_valid", cmd_valid, 0);
    check("t5_idle_cmd", cmd, CMD_NONE);
    watch(15, -1);
    check("t5_no_extra", hs_idx.size(), 0);

    // 6: reset pulse during soft-drop repeat aborts everything
    btn_down = 1'b1;
    watch(20, -1);
    check("t6_repeating", (hs_idx.size() >= 3) ? 1 : 0, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_cmd", cmd, CMD_NONE);
    reset_n = 1'b1;
    watch(16, 5);
    check("t6_first_cycle", idx_at(0), 7);
    check("t6_count", hs_idx.size(), 1);
    check("t6_wrong_cmds", count_not(CMD_SOFT_DROP), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
